alu_ctrl_seq: RTL and testbench

ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

---
 rtl/alu_pkg.sv | 68 ++++++
 rtl/alu_decode.sv | 56 +++++
 rtl/alu_ctrl_seq.sv | 135 +++++++++++++
 tb/tb_alu_ctrl_seq.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU control decoder and its sequencer.
// Contents: aluctl codes, aluop values, func7 selectors, FSM state encoding,
// the registered control payload struct and the shared base-op lookup.
package alu_pkg;

   localparam int unsigned ALUCTL_W = 4;
   localparam int unsigned ALUOP_W  = 2;
   localparam int unsigned FUNC7_W  = 7;
   localparam int unsigned FUNC3_W  = 3;
   localparam int unsigned STATE_W  = 2;

   // ALU operation codes
   localparam logic [ALUCTL_W-1:0] ALU_AND  = 4'b0000;
   localparam logic [ALUCTL_W-1:0] ALU_OR   = 4'b0001;
   localparam logic [ALUCTL_W-1:0] ALU_ADD  = 4'b0010;
   localparam logic [ALUCTL_W-1:0] ALU_SLL  = 4'b0011;
   localparam logic [ALUCTL_W-1:0] ALU_SRL  = 4'b0100;
   localparam logic [ALUCTL_W-1:0] ALU_SRA  = 4'b0101;
   localparam logic [ALUCTL_W-1:0] ALU_SUB  = 4'b0110;
   localparam logic [ALUCTL_W-1:0] ALU_SLT  = 4'b0111;
   localparam logic [ALUCTL_W-1:0] ALU_BNE  = 4'b1000;
   localparam logic [ALUCTL_W-1:0] ALU_SLTU = 4'b1001;
   localparam logic [ALUCTL_W-1:0] ALU_SGE  = 4'b1010;
   localparam logic [ALUCTL_W-1:0] ALU_SGEU = 4'b1011;
   localparam logic [ALUCTL_W-1:0] ALU_XOR  = 4'b1100;

   // aluop classes
   localparam logic [ALUOP_W-1:0] ALUOP_MEM    = 2'b00;
   localparam logic [ALUOP_W-1:0] ALUOP_BRANCH = 2'b01;
   localparam logic [ALUOP_W-1:0] ALUOP_RTYPE  = 2'b10;
   localparam logic [ALUOP_W-1:0] ALUOP_ADD    = 2'b11;

   // func7 selectors for R-type
   localparam logic [FUNC7_W-1:0] F7_BASE   = 7'b0000000;
   localparam logic [FUNC7_W-1:0] F7_ALT    = 7'b0100000;
   localparam logic [FUNC7_W-1:0] F7_MULDIV = 7'b0000001;

   // FSM state encoding
   localparam logic [STATE_W-1:0] ST_IDLE     = 2'd0;
   localparam logic [STATE_W-1:0] ST_HOLD     = 2'd1;
   localparam logic [STATE_W-1:0] ST_MDU_WAIT = 2'd2;

   // Decoded control payload held in the output register
   typedef struct packed {
      logic [ALUCTL_W-1:0] aluctl;
      logic                is_mdu;
      logic [FUNC3_W-1:0]  mdu_op;
      logic                illegal;
   } ctl_t;

   // func3 -> op for immediate/load-store and base R-type; arith picks SRA over SRL
   function automatic logic [ALUCTL_W-1:0] base_aluctl(input logic [FUNC3_W-1:0] func3,
                                                       input logic              arith);
      logic [ALUCTL_W-1:0] op;
      case (func3)
         3'b000:  op = ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = arith ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational ALU control decode.
// Ports: aluop/func7/func3 instruction fields in; aluctl, is_mdu, mdu_op,
// illegal out. Unsupported combinations yield aluctl=AND(0000), illegal=1.
module alu_decode
   import alu_pkg::*;
(
   input  logic [ALUOP_W-1:0]  aluop,
   input  logic [FUNC7_W-1:0]  func7,
   input  logic [FUNC3_W-1:0]  func3,
   output logic [ALUCTL_W-1:0] aluctl,
   output logic                is_mdu,
   output logic [FUNC3_W-1:0]  mdu_op,
   output logic                illegal
);

   // Field decode; every output defaulted so nothing can latch
   always_comb begin
      aluctl  = ALU_AND;
      is_mdu  = 1'b0;
      mdu_op  = '0;
      illegal = 1'b0;
      case (aluop)
         ALUOP_MEM: aluctl = base_aluctl(func3, func7[5]);
         ALUOP_BRANCH: begin
            case (func3)
               3'b000:  aluctl = ALU_SUB;
               3'b001:  aluctl = ALU_BNE;
               3'b100:  aluctl = ALU_SLT;
               3'b101:  aluctl = ALU_SGE;
               3'b110:  aluctl = ALU_SLTU;
               3'b111:  aluctl = ALU_SGEU;
               default: illegal = 1'b1;
            endcase
         end
         ALUOP_RTYPE: begin
            if (func7 == F7_BASE) begin
               aluctl = base_aluctl(func3, 1'b0);
            end else if (func7 == F7_ALT) begin
               case (func3)
                  3'b000:  aluctl = ALU_SUB;
                  3'b101:  aluctl = ALU_SRA;
                  default: illegal = 1'b1;
               endcase
            end else if (func7 == F7_MULDIV) begin
               is_mdu = 1'b1;
               mdu_op = func3;
               aluctl = ALU_ADD;
            end else begin
               illegal = 1'b1;
            end
         end
         default: aluctl = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/alu_ctrl_seq.sv
// ALU control sequencer: decodes a request, holds the result under a
// valid/ready handshake and stretches multiply/divide ops to their latency.
// Ports: clk, rst (sync, active-high); in_valid/in_ready request handshake
// with aluop/func7/func3; flush kills pending work; out_valid/out_ready
// result handshake with aluctl, is_mdu, mdu_op, illegal; busy flags an
// MDU op in flight.
module alu_ctrl_seq
   import alu_pkg::*;
#(
   parameter int unsigned MUL_LAT = 2,
   parameter int unsigned DIV_LAT = 32,
   parameter int unsigned CNT_W   = 6
)
(
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [ALUOP_W-1:0]  aluop,
   input  logic [FUNC7_W-1:0]  func7,
   input  logic [FUNC3_W-1:0]  func3,
   input  logic                flush,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [ALUCTL_W-1:0] aluctl,
   output logic                is_mdu,
   output logic [FUNC3_W-1:0]  mdu_op,
   output logic                illegal,
   output logic                busy
);

   localparam logic [CNT_W-1:0] MUL_LOAD  = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT - 1);
   localparam logic             MUL_MULTI = (MUL_LAT > 1);
   localparam logic             DIV_MULTI = (DIV_LAT > 1);

   logic [STATE_W-1:0] state, state_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic               out_valid_n, busy_n, load, accept;
   ctl_t               dec, ctl_q;

   alu_decode u_decode (
      .aluop   (aluop),
      .func7   (func7),
      .func3   (func3),
      .aluctl  (dec.aluctl),
      .is_mdu  (dec.is_mdu),
      .mdu_op  (dec.mdu_op),
      .illegal (dec.illegal)
   );

   // Ready follows the state; in HOLD a new op may only replace a consumed one
   assign in_ready = (state == ST_IDLE) || ((state == ST_HOLD) && out_ready);
   assign accept   = in_valid && in_ready && !flush;

   // Next-state and next-output logic
   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      out_valid_n = out_valid;
      busy_n      = busy;
      load        = 1'b0;
      case (state)
         ST_IDLE, ST_HOLD: begin
            if (accept) begin
               load = 1'b1;
               // A 1-cycle MDU op times exactly like a plain decode
               if (dec.is_mdu && (dec.mdu_op[2] ? DIV_MULTI : MUL_MULTI)) begin
                  state_n     = ST_MDU_WAIT;
                  cnt_n       = dec.mdu_op[2] ? DIV_LOAD : MUL_LOAD;
                  busy_n      = 1'b1;
                  out_valid_n = 1'b0;
               end else begin
                  state_n     = ST_HOLD;
                  out_valid_n = 1'b1;
                  busy_n      = 1'b0;
               end
            end else if ((state == ST_HOLD) && out_ready) begin
               state_n     = ST_IDLE;
               out_valid_n = 1'b0;
            end
         end
         ST_MDU_WAIT: begin
            // Counter reaches 0 on the same edge that raises out_valid
            if (cnt <= CNT_W'(1)) begin
               state_n     = ST_HOLD;
               cnt_n       = '0;
               busy_n      = 1'b0;
               out_valid_n = 1'b1;
            end else begin
               cnt_n = cnt - CNT_W'(1);
            end
         end
         default: begin
            state_n     = ST_IDLE;
            cnt_n       = '0;
            busy_n      = 1'b0;
            out_valid_n = 1'b0;
         end
      endcase
      // Flush beats both a same-cycle accept and counter expiry
      if (flush) begin
         state_n     = ST_IDLE;
         cnt_n       = '0;
         busy_n      = 1'b0;
         out_valid_n = 1'b0;
         load        = 1'b0;
      end
   end

   // State, counter and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         ctl_q     <= '0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         out_valid <= out_valid_n;
         busy      <= busy_n;
         if (load) begin
            ctl_q <= dec;
         end
      end
   end

   assign aluctl  = ctl_q.aluctl;
   assign is_mdu  = ctl_q.is_mdu;
   assign mdu_op  = ctl_q.mdu_op;
   assign illegal = ctl_q.illegal;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: directed scenarios plus randomized
// single-op traffic checked against a table-driven reference decode and a
// latency model.
module tb_alu_ctrl_seq;

   localparam int unsigned MUL_LAT = 2;
   localparam int unsigned DIV_LAT = 32;
   localparam int unsigned CNT_W   = 6;

   logic       clk = 1'b0;
   logic       rst, in_valid, in_ready, flush, out_valid, out_ready;
   logic       is_mdu, illegal, busy;
   logic [1:0] aluop;
   logic [6:0] func7;
   logic [2:0] func3, mdu_op;
   logic [3:0] aluctl;

   int n_tests = 0;
   int n_fail  = 0;

   alu_ctrl_seq #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .aluop(aluop), .func7(func7), .func3(func3), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .aluctl(aluctl),
      .is_mdu(is_mdu), .mdu_op(mdu_op), .illegal(illegal), .busy(busy)
   );

   always #5 clk = ~clk;

   // Reference decode: returns {illegal, is_mdu, mdu_op, aluctl}
   function automatic logic [8:0] ref_decode(input logic [1:0] op, input logic [6:0] f7,
                                             input logic [2:0] f3);
      logic [3:0] base [8];
      logic [3:0] br [8];
      logic [7:0] br_ok;
      logic [8:0] bad;
      base  = '{4'd2, 4'd3, 4'd7, 4'd9, 4'd12, 4'd4, 4'd1, 4'd0};
      br    = '{4'd6, 4'd8, 4'd0, 4'd0, 4'd7, 4'd10, 4'd9, 4'd11};
      br_ok = 8'b1111_0011;
      bad   = 9'b1_0_000_0000;
      if (op == 2'd3) return {2'b00, 3'd0, 4'd2};
      if (op == 2'd0) return {2'b00, 3'd0, (f3 == 3'd5 && f7[5]) ? 4'd5 : base[f3]};
      if (op == 2'd1) return br_ok[f3] ? {2'b00, 3'd0, br[f3]} : bad;
      if (f7 == 7'h00) return {2'b00, 3'd0, base[f3]};
      if (f7 == 7'h20) begin
         if (f3 == 3'd0) return {2'b00, 3'd0, 4'd6};
         if (f3 == 3'd5) return {2'b00, 3'd0, 4'd5};
         return bad;
      end
      if (f7 == 7'h01) return {2'b01, f3, 4'd2};
      return bad;
   endfunction

   function automatic int ref_lat(input logic [8:0] e, input logic [2:0] f3);
      if (!e[7]) return 1;
      return f3[2] ? DIV_LAT : MUL_LAT;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3);
      aluop = op;
      func7 = f7;
      func3 = f3;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      drive(2'd0, 7'd0, 3'd0);
      tick(); tick();
      n_tests++;
      if ({out_valid, busy, aluctl, is_mdu, mdu_op, illegal} !== 11'd0) begin
         n_fail++;
         $display("FAIL reset_outputs got %b expected all zero", {out_valid, busy, aluctl, is_mdu, mdu_op, illegal});
      end
      rst = 1'b0;
      n_tests++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b expected 1", in_ready); end
      tick();
      n_tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_idle got valid=%b ready=%b expected 0/1", out_valid, in_ready);
      end
   endtask

   task automatic test_sra();
      drive(2'd2, 7'h20, 3'd5); out_ready = 1'b1; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n_tests++;
      if ({out_valid, aluctl, illegal, is_mdu} !== {1'b1, 4'b0101, 1'b0, 1'b0}) begin
         n_fail++; $display("FAIL sra_decode got v=%b ctl=%b ill=%b expected v=1 ctl=0101 ill=0", out_valid, aluctl, illegal);
      end
      tick();
      n_tests++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sra_release got out_valid=%b expected 0", out_valid); end
   endtask

   task automatic test_back_to_back();
      logic [2:0] f3s [4];
      logic [3:0] exp_ctl [4];
      f3s     = '{3'd0, 3'd4, 3'd6, 3'd1};
      exp_ctl = '{4'd2, 4'd12, 4'd1, 4'd3};
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(2'd2, 7'h00, f3s[i]); in_valid = 1'b1;
         n_tests++;
         if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d] got %b expected 1", i, in_ready); end
         tick();
         n_tests++;
         if ({out_valid, aluctl} !== {1'b1, exp_ctl[i]}) begin
            n_fail++; $display("FAIL b2b_out[%0d] got v=%b ctl=%b expected v=1 ctl=%b", i, out_valid, aluctl, exp_ctl[i]);
         end
      end
      in_valid = 1'b0;
      tick();
      n_tests++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got out_valid=%b expected 0", out_valid); end
   endtask

   task automatic test_div();
      int k, busy_cycles, ready_bad;
      drive(2'd2, 7'h01, 3'd4); out_ready = 1'b1; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      k = 1; busy_cycles = 0; ready_bad = 0;
      while (out_valid !== 1'b1 && k < 60) begin
         if (busy === 1'b1) busy_cycles++;
         if (in_ready !== 1'b0) ready_bad++;
         tick(); k++;
      end
      n_tests++;
      if (k != int'(DIV_LAT)) begin n_fail++; $display("FAIL div_latency got %0d expected %0d", k, DIV_LAT); end
      n_tests++;
      if (busy_cycles != int'(DIV_LAT) - 1) begin n_fail++; $display("FAIL div_busy_cycles got %0d expected %0d", busy_cycles, DIV_LAT - 1); end
      n_tests++;
      if (ready_bad != 0) begin n_fail++; $display("FAIL div_in_ready got %0d ready cycles expected 0", ready_bad); end
      n_tests++;
      if ({busy, aluctl, is_mdu, mdu_op, illegal} !== {1'b0, 4'b0010, 1'b1, 3'b100, 1'b0}) begin
         n_fail++; $display("FAIL div_fields got busy=%b ctl=%b mdu=%b op=%b ill=%b expected 0 0010 1 100 0", busy, aluctl, is_mdu, mdu_op, illegal);
      end
      tick();
      n_tests++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL div_release got out_valid=%b expected 0", out_valid); end
   endtask

   task automatic test_illegal_stall();
      drive(2'd1, 7'h00, 3'd2); out_ready = 1'b0; in_valid = 1'b1;
      tick();
      drive(2'd3, 7'h00, 3'd0);
      n_tests++;
      if ({out_valid, aluctl, illegal, is_mdu} !== {1'b1, 4'b0000, 1'b1, 1'b0}) begin
         n_fail++; $display("FAIL illegal_decode got v=%b ctl=%b ill=%b expected v=1 ctl=0000 ill=1", out_valid, aluctl, illegal);
      end
      for (int s = 0; s < 5; s++) begin
         tick();
         n_tests++;
         if ({out_valid, aluctl, illegal, is_mdu, mdu_op, in_ready} !== {1'b1, 4'b0000, 1'b1, 1'b0, 3'b000, 1'b0}) begin
            n_fail++; $display("FAIL illegal_stall[%0d] got v=%b ctl=%b ill=%b rdy=%b expected stable v=1 ctl=0000 ill=1 rdy=0", s, out_valid, aluctl, illegal, in_ready);
         end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
      n_tests++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL illegal_release got out_valid=%b expected 0", out_valid); end
   endtask

   task automatic test_flush();
      int seen;
      // Flush in IDLE beats a concurrent request
      drive(2'd3, 7'h00, 3'd0); out_ready = 1'b1; in_valid = 1'b1; flush = 1'b1;
      tick();
      in_valid = 1'b0; flush = 1'b0;
      n_tests++;
      if ({out_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL flush_idle got v=%b busy=%b expected 0/0", out_valid, busy); end
      // Flush at cycle 10 of a divide with a concurrent request
      drive(2'd2, 7'h01, 3'd5); in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      drive(2'd3, 7'h00, 3'd0); in_valid = 1'b1; flush = 1'b1;
      tick();
      in_valid = 1'b0; flush = 1'b0;
      n_tests++;
      if ({out_valid, busy, in_ready} !== 3'b001) begin
         n_fail++; $display("FAIL flush_div got v=%b busy=%b rdy=%b expected 0/0/1", out_valid, busy, in_ready);
      end
      seen = 0;
      for (int i = 0; i < 40; i++) begin if (out_valid !== 1'b0) seen++; tick(); end
      n_tests++;
      if (seen != 0) begin n_fail++; $display("FAIL flush_div_quiet got %0d valid cycles expected 0", seen); end
      // Flush on the cycle the multiply counter expires
      drive(2'd2, 7'h01, 3'd0); in_valid = 1'b1;
      tick();
      in_valid = 1'b0; flush = 1'b1;
      tick();
      flush = 1'b0;
      seen = 0;
      for (int i = 0; i < 5; i++) begin if (out_valid !== 1'b0 || busy !== 1'b0) seen++; tick(); end
      n_tests++;
      if (seen != 0) begin n_fail++; $display("FAIL flush_expiry got %0d active cycles expected 0", seen); end
      // Flush drops a held result
      drive(2'd0, 7'h00, 3'd6); out_ready = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0; flush = 1'b1;
      tick();
      flush = 1'b0; out_ready = 1'b1;
      n_tests++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_hold got out_valid=%b expected 0", out_valid); end
   endtask

   task automatic test_rst_mid();
      int seen;
      drive(2'd2, 7'h01, 3'd6); out_ready = 1'b1; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      rst = 1'b1;
      tick();
      n_tests++;
      if ({out_valid, busy, aluctl, is_mdu, mdu_op, illegal} !== 11'd0) begin
         n_fail++; $display("FAIL rst_mdu_outputs got %b expected all zero", {out_valid, busy, aluctl, is_mdu, mdu_op, illegal});
      end
      rst = 1'b0;
      n_tests++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mdu_in_ready got %b expected 1", in_ready); end
      seen = 0;
      for (int i = 0; i < 40; i++) begin tick(); if (out_valid !== 1'b0) seen++; end
      n_tests++;
      if (seen != 0) begin n_fail++; $display("FAIL rst_mdu_quiet got %0d valid cycles expected 0", seen); end
      // Reset while holding a result
      drive(2'd0, 7'h00, 3'd1); out_ready = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0; out_ready = 1'b1;
      seen = 0;
      for (int i = 0; i < 3; i++) begin if (out_valid !== 1'b0 || aluctl !== 4'd0) seen++; tick(); end
      n_tests++;
      if (seen != 0) begin n_fail++; $display("FAIL rst_hold got %0d bad cycles expected 0", seen); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 80; n++) begin
         logic [8:0] e;
         logic [6:0] f7;
         logic [2:0] f3;
         logic [1:0] op;
         int lat, k, busy_bad, stall;
         op = 2'($urandom_range(0, 3));
         f3 = 3'($urandom);
         case ($urandom_range(0, 3))
            0:       f7 = 7'h00;
            1:       f7 = 7'h20;
            2:       f7 = 7'h01;
            default: f7 = 7'($urandom);
         endcase
         e   = ref_decode(op, f7, f3);
         lat = ref_lat(e, f3);
         drive(op, f7, f3); out_ready = 1'($urandom); in_valid = 1'b1;
         #1;
         n_tests++;
         if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rand_in_ready[%0d] got %b expected 1", n, in_ready); end
         tick();
         in_valid = 1'b0; out_ready = 1'b0;
         drive(2'($urandom), 7'($urandom), 3'($urandom));
         k = 1; busy_bad = 0;
         while (out_valid !== 1'b1 && k < 60) begin
            if (busy !== e[7]) busy_bad++;
            tick(); k++;
         end
         n_tests++;
         if (k != lat || busy_bad != 0) begin
            n_fail++; $display("FAIL rand_timing[%0d] got latency %0d busy_err %0d expected %0d/0", n, k, busy_bad, lat);
         end
         n_tests++;
         if ({illegal, is_mdu, mdu_op, aluctl, busy} !== {e, 1'b0}) begin
            n_fail++; $display("FAIL rand_decode[%0d] op=%b f7=%b f3=%b got %b expected %b", n, op, f7, f3, {illegal, is_mdu, mdu_op, aluctl, busy}, {e, 1'b0});
         end
         stall = $urandom_range(0, 3);
         for (int s = 0; s < stall; s++) begin
            tick();
            n_tests++;
            if ({out_valid, in_ready, illegal, is_mdu, mdu_op, aluctl} !== {2'b10, e}) begin
               n_fail++; $display("FAIL rand_stall[%0d] got %b expected %b", n, {out_valid, in_ready, illegal, is_mdu, mdu_op, aluctl}, {2'b10, e});
            end
         end
         out_ready = 1'b1;
         tick();
         n_tests++;
         if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rand_release[%0d] got out_valid=%b expected 0", n, out_valid); end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_sra();
      test_back_to_back();
      test_div();
      test_illegal_stall();
      test_flush();
      test_rst_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
